// File: rtl/imgproc_poll_pkg.sv
// imgproc_poll_pkg: shared types and constants for the image-processor message poller.
// Holds the poller state enum, the MM sequencer phase enum, slave register
// addresses, the FIFO flush command, and x/y field extraction from a message word.
package imgproc_poll_pkg;

  typedef enum logic [2:0] {
    ID_CHK, IDLE, STAT, HDR, BODY, RESYNC, PRESENT, FAIL
  } poll_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE, SEQ_STROBE, SEQ_CAP
  } seq_phase_e;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;

  localparam int          FLUSH_BIT = 4;
  localparam logic [31:0] FLUSH_CMD = 32'(1) << FLUSH_BIT;

  function automatic logic [10:0] word_x(input logic [31:0] w);
    return w[26:16];
  endfunction

  function automatic logic [10:0] word_y(input logic [31:0] w);
    return w[10:0];
  endfunction

endpackage

// File: rtl/imgproc_mm_rd_seq.sv
// imgproc_mm_rd_seq: single-access Avalon-MM sequencer, sole driver of the m_* ports.
// Ports: req/wr/addr/wdata request in; done pulses with rdata (= m_readdata) in the
// capture cycle; m_* strobes are registered. Access = idle/gap, strobe, capture (3 cycles).
module imgproc_mm_rd_seq
  import imgproc_poll_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  seq_phase_e  phase_q, phase_d;
  logic        cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // The idle phase doubles as the mandatory gap: a request is only taken there,
  // so two strobes are always at least three cycles apart.
  always_comb begin
    phase_d = phase_q;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (phase_q)
      SEQ_IDLE: begin
        if (req) begin
          phase_d = SEQ_STROBE;
          cs_d    = 1'b1;
          rd_d    = ~wr;
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = wr ? wdata : '0;
        end
      end
      SEQ_STROBE: phase_d = SEQ_CAP;
      SEQ_CAP:    phase_d = SEQ_IDLE;
      default:    phase_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= SEQ_IDLE;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Slave drives read data in the cycle after the strobe; writes finish the same way.
  assign done         = (phase_q == SEQ_CAP);
  assign rdata        = m_readdata;
  assign m_chipselect = cs_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_address    = addr_q;
  assign m_writedata  = wdata_q;

endmodule

// File: rtl/imgproc_msg_poller.sv
// imgproc_msg_poller: drains the image processor message FIFO over Avalon-MM into one
// parallel bounding-box record (out_valid/out_ready); checks ID, polls fill level, counts bad headers.
// Ports: clk/reset_n, enable, m_* MM master, out_* record, id_ok, err_count. Option: IMGPROC_POLL_FLUSH_EN.
module imgproc_msg_poller
  import imgproc_poll_pkg::*;
#(
  parameter logic [15:0] POLL_INTERVAL = 16'd50000,
  parameter int          MSG_WORDS     = 7,
  parameter logic [31:0] MSG_HEADER    = 32'h00524259,
  parameter logic [31:0] EXPECT_ID     = 32'h1234EEE2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [43:0] out_box_r,
  output logic [43:0] out_box_b,
  output logic [43:0] out_box_y,
  output logic [2:0]  out_present,
  output logic        id_ok,
  output logic [7:0]  err_count
);

  localparam int          NC     = MSG_WORDS - 1;
  localparam logic [15:0] RELOAD = POLL_INTERVAL - 16'd1;

  poll_state_e          state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           err_q, err_d;
  logic                 id_ok_q, id_ok_d;
  // Corners in arrival order {x,y}: r min, r max, b min, b max, y min, y max.
  logic [NC-1:0][21:0]  corner_q, corner_d;

  logic        seq_req, seq_wr, seq_done;
  logic [2:0]  seq_addr;
  logic [31:0] seq_wdata, seq_rdata;

  imgproc_mm_rd_seq u_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (seq_req),
    .wr           (seq_wr),
    .addr         (seq_addr),
    .wdata        (seq_wdata),
    .done         (seq_done),
    .rdata        (seq_rdata),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    err_d     = err_q;
    id_ok_d   = id_ok_q;
    corner_d  = corner_q;
    seq_req   = 1'b0;
    seq_wr    = 1'b0;
    seq_addr  = ADDR_STATUS;
    seq_wdata = FLUSH_CMD;
    unique case (state_q)
      ID_CHK: begin
        seq_req  = 1'b1;
        seq_addr = ADDR_ID;
        if (seq_done) begin
          if (seq_rdata == EXPECT_ID) begin
            id_ok_d = 1'b1;
            state_d = IDLE;
            timer_d = RELOAD;
          end else begin
            state_d = FAIL;
          end
        end
      end
      IDLE: begin
        // Timer parks at 0 while enable is low; polling resumes on the first enabled cycle.
        if (timer_q != 16'd0) timer_d = timer_q - 16'd1;
        else if (enable)      state_d = STAT;
      end
      STAT: begin
        seq_req  = 1'b1;
        seq_addr = ADDR_STATUS;
        if (seq_done) begin
          if (seq_rdata[15:8] >= 8'(MSG_WORDS)) begin
            state_d = HDR;
          end else begin
            state_d = IDLE;
            timer_d = RELOAD;
          end
        end
      end
      HDR: begin
        seq_req  = 1'b1;
        seq_addr = ADDR_MSG;
        if (seq_done) begin
          if (seq_rdata == MSG_HEADER) begin
            state_d = BODY;
            idx_d   = 3'd1;
          end else begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = RESYNC;
          end
        end
      end
      BODY: begin
        seq_req  = 1'b1;
        seq_addr = ADDR_MSG;
        if (seq_done) begin
          corner_d[idx_q - 3'd1] = {word_x(seq_rdata), word_y(seq_rdata)};
          if (idx_q == 3'(MSG_WORDS - 1)) state_d = PRESENT;
          else                            idx_d   = idx_q + 3'd1;
        end
      end
      RESYNC: begin
`ifdef IMGPROC_POLL_FLUSH_EN
        seq_req  = 1'b1;
        seq_wr   = 1'b1;
        seq_addr = ADDR_STATUS;
        if (seq_done) begin
          state_d = IDLE;
          timer_d = RELOAD;
        end
`else
        // No flush: later polls discard stale words one header read at a time.
        state_d = IDLE;
        timer_d = RELOAD;
`endif
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = IDLE;
          timer_d = RELOAD;
        end
      end
      FAIL: state_d = FAIL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ID_CHK;
      timer_q  <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      id_ok_q  <= 1'b0;
      corner_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      id_ok_q  <= id_ok_d;
      corner_q <= corner_d;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign out_box_r = {corner_q[0], corner_q[1]};
  assign out_box_b = {corner_q[2], corner_q[3]};
  assign out_box_y = {corner_q[4], corner_q[5]};
  assign id_ok     = id_ok_q;
  assign err_count = err_q;

  // Gated by out_valid so the cleared boxes after reset (0 <= 0) do not read as present.
  assign out_present = out_valid ? {corner_q[4][21:11] <= corner_q[5][21:11],
                                    corner_q[2][21:11] <= corner_q[3][21:11],
                                    corner_q[0][21:11] <= corner_q[1][21:11]} : 3'b000;

endmodule
